// File: rtl/mpi_bus_master.sv
// MPI (Q-bus style) bus master: acquires the bus via DMR/DMGI/SACK and runs one
// DATI, DATO or DATOB cycle per request. byte_en is the DATOB select ("byte" is reserved).
module mpi_bus_master #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        byte_en,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy,
    input  logic [15:0] ad_in_n,
    output logic [15:0] ad_out_n,
    output logic        ad_oe,
    input  logic        sync_in_n,
    output logic        sync_n,
    output logic        din_n,
    output logic        dout_n,
    output logic        wtbt_n,
    input  logic        rply_n,
    output logic        dmr_n,
    input  logic        dmgi_n,
    output logic        dmgo_n,
    output logic        sack_n
);
    typedef enum logic [3:0] {
        IDLE, BREQ, GRANT, ADDR, ASYNC, RSTB, WDAT, WSTB, TERM, DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic        byte_q;
    logic [1:0]  rply_sync;
    logic        rply_s;
    logic [7:0]  tmo_cnt;

    assign rply_s = rply_sync[1];
    assign busy   = (state != IDLE);
    // Grant is passed down the daisy chain only while this master is not competing.
    assign dmgo_n = (state == IDLE) ? dmgi_n : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rply_sync <= '1;
        end else begin
            rply_sync <= {rply_sync[0], rply_n};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            tmo_cnt  <= '0;
            rdata    <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
            ad_out_n <= '1;
            ad_oe    <= 1'b0;
            sync_n   <= 1'b1;
            din_n    <= 1'b1;
            dout_n   <= 1'b1;
            wtbt_n   <= 1'b1;
            dmr_n    <= 1'b1;
            sack_n   <= 1'b1;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    addr_q  <= addr;
                    wdata_q <= wdata;
                    we_q    <= we;
                    byte_q  <= byte_en;
                    dmr_n   <= 1'b0;
                    state   <= BREQ;
                end
                BREQ: if (!dmgi_n) begin
                    dmr_n  <= 1'b1;
                    sack_n <= 1'b0;
                    state  <= GRANT;
                end
                GRANT: if (sync_in_n && rply_s) begin
                    ad_oe    <= 1'b1;
                    ad_out_n <= ~addr_q;
                    wtbt_n   <= ~we_q;
                    state    <= ADDR;
                end
                ADDR: begin
                    sync_n <= 1'b0;
                    state  <= ASYNC;
                end
                ASYNC: begin
                    tmo_cnt <= '0;
                    if (we_q) begin
                        ad_out_n <= ~wdata_q;
                        wtbt_n   <= ~byte_q;
                        state    <= WDAT;
                    end else begin
                        ad_oe    <= 1'b0;
                        ad_out_n <= '1;
                        din_n    <= 1'b0;
                        state    <= RSTB;
                    end
                end
                WDAT: begin
                    tmo_cnt <= '0;
                    dout_n  <= 1'b0;
                    state   <= WSTB;
                end
                RSTB, WSTB: begin
                    if (!rply_s) begin
                        if (state == RSTB) rdata <= ~ad_in_n;
                        din_n    <= 1'b1;
                        dout_n   <= 1'b1;
                        ad_oe    <= 1'b0;
                        ad_out_n <= '1;
                        wtbt_n   <= 1'b1;
                        state    <= TERM;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // No reply: release the whole bus at once and skip TERM.
                        din_n    <= 1'b1;
                        dout_n   <= 1'b1;
                        ad_oe    <= 1'b0;
                        ad_out_n <= '1;
                        wtbt_n   <= 1'b1;
                        sync_n   <= 1'b1;
                        sack_n   <= 1'b1;
                        ack      <= 1'b1;
                        err      <= 1'b1;
                        state    <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                TERM: if (rply_s) begin
                    sync_n <= 1'b1;
                    sack_n <= 1'b1;
                    ack    <= 1'b1;
                    state  <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpi_bus_master.sv
// Bench for mpi_bus_master: a RAM slave on the bus, directed vector table, hand-written
// grant/timeout/reset sequences and random traffic checked against a word-array model.
module tb_mpi_bus_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        byt = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        ack, err, busy;
    logic [15:0] ad_in_n = '1;
    logic [15:0] ad_out_n;
    logic        ad_oe;
    wire         sync_in_n;
    logic        sync_n, din_n, dout_n, wtbt_n;
    logic        rply_n = 1'b1;
    logic        dmr_n;
    wire         dmgi_n;
    logic        dmgo_n, sack_n;

    logic        grant_auto = 1'b1;
    logic        grant_manual = 1'b1;
    logic        other_sync_n = 1'b1;
    logic        mute = 1'b0;
    int unsigned resp_delay = 2;
    logic        dmr_d = 1'b1;
    logic        prev_sync_s = 1'b1;
    logic [15:0] s_addr = '0;
    int unsigned s_wait = 0;
    logic        ram_ready = 1'b0;
    logic [15:0] ram [0:511];
    logic [15:0] ref_mem [0:511];
    logic [15:0] last_rd;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    assign sync_in_n = sync_n & other_sync_n;
    assign dmgi_n    = grant_auto ? dmr_d : grant_manual;

    mpi_bus_master #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .byte_en(byt), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy),
        .ad_in_n(ad_in_n), .ad_out_n(ad_out_n), .ad_oe(ad_oe), .sync_in_n(sync_in_n),
        .sync_n(sync_n), .din_n(din_n), .dout_n(dout_n), .wtbt_n(wtbt_n),
        .rply_n(rply_n), .dmr_n(dmr_n), .dmgi_n(dmgi_n), .dmgo_n(dmgo_n), .sack_n(sack_n)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_pat(input int unsigned i);
        return 16'(i * 32'h0101) ^ 16'h5A5A;
    endfunction

    // RAM slave: latches the address on SYNC fall, answers DIN/DOUT after resp_delay.
    always @(negedge clk) begin
        logic [15:0] d;
        if (!ram_ready) begin
            for (int i = 0; i < 512; i++) ram[i] = init_pat(i);
            ram_ready = 1'b1;
        end
        dmr_d = dmr_n;
        if (prev_sync_s && !sync_n) s_addr = ~ad_out_n;
        prev_sync_s = sync_n;
        if (din_n && dout_n) begin
            rply_n  = 1'b1;
            ad_in_n = '1;
            s_wait  = 0;
        end else if (rply_n && !mute) begin
            if (s_wait < resp_delay) begin
                s_wait++;
            end else begin
                if (!din_n) begin
                    ad_in_n = ~ram[s_addr[9:1]];
                end else begin
                    d = ~ad_out_n;
                    if (wtbt_n) ram[s_addr[9:1]] = d;
                    else if (s_addr[0]) ram[s_addr[9:1]][15:8] = d[15:8];
                    else ram[s_addr[9:1]][7:0] = d[7:0];
                end
                rply_n = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_write(input logic [15:0] a, input logic [15:0] d, input logic b);
        if (!b) ref_mem[a[9:1]] = d;
        else if (a[0]) ref_mem[a[9:1]][15:8] = d[15:8];
        else ref_mem[a[9:1]][7:0] = d[7:0];
    endtask

    task automatic xfer(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d,
                        input logic exp_err, input logic [15:0] exp_rd, output int unsigned din_low);
        logic got_ack = 1'b0, prev_sync = 1'b1, prev_sack = 1'b1;
        logic seen_a = 1'b0, seen_d = 1'b0, wt_a = 1'b1, wt_d = 1'b1;
        logic [15:0] bus_a = '1, bus_d = '1;
        int unsigned falls = 0;
        din_low = 0;
        @(posedge clk); #1;
        chk("idle_before_req", busy, 0);
        we = w; byt = b; addr = a; wdata = d; req = 1'b1;
        for (int cyc = 0; cyc < 200 && !got_ack; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
                req = 1'b0; we = ~w; byt = ~b; addr = ~a; wdata = ~d;
            end
            if (ad_oe && sync_n && !seen_a) begin seen_a = 1'b1; bus_a = ad_out_n; wt_a = wtbt_n; end
            if (!dout_n && !seen_d) begin seen_d = 1'b1; bus_d = ad_out_n; wt_d = wtbt_n; end
            if (!din_n) din_low++;
            if (prev_sync && !sync_n) falls++;
            if (ack) begin
                got_ack = 1'b1;
                chk("err_flag", err, exp_err);
                chk("rdata", rdata, exp_rd);
                chk("bus_released", {sync_n, sack_n, din_n, dout_n, dmr_n, wtbt_n, ad_oe}, 7'b1111110);
                chk("sync_sack_before_ack", {prev_sync, prev_sack}, 2'b00);
            end else begin
                prev_sync = sync_n;
                prev_sack = sack_n;
            end
        end
        chk("ack_within_budget", got_ack, 1);
        chk("one_sync_window", falls, 1);
        chk("addr_phase", {seen_a, wt_a, bus_a}, {1'b1, ~w, ~a});
        if (w) chk("data_phase", {seen_d, wt_d, bus_d}, {1'b1, ~b, ~d});
        @(posedge clk); #1;
        chk("ack_one_cycle", {ack, err, busy}, 3'b000);
    endtask

    typedef struct {
        logic        w;
        logic        b;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp_rd;
    } vec_t;

    initial begin
        vec_t        tbl [10];
        int unsigned dl, cnt, cnt2;
        logic        found;
        logic        w, b;
        logic [15:0] a, d, e;

        tbl = '{
            '{1'b1, 1'b0, 16'o001000, 16'h1234, 16'h0000},
            '{1'b0, 1'b0, 16'o001000, 16'h0000, 16'h1234},
            '{1'b1, 1'b0, 16'o000400, 16'hA55A, 16'h1234},
            '{1'b0, 1'b0, 16'o000400, 16'h0000, 16'hA55A},
            '{1'b1, 1'b1, 16'o000401, 16'h00C3, 16'hA55A},
            '{1'b0, 1'b0, 16'o000400, 16'h0000, 16'h005A},
            '{1'b1, 1'b1, 16'o000400, 16'h7E11, 16'h005A},
            '{1'b0, 1'b0, 16'o000400, 16'h0000, 16'h0011},
            '{1'b1, 1'b1, 16'o001001, 16'hBEEF, 16'h0011},
            '{1'b0, 1'b0, 16'o001000, 16'h0000, 16'hBE34}
        };
        for (int i = 0; i < 512; i++) ref_mem[i] = init_pat(i);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_bus", {sync_n, din_n, dout_n, wtbt_n, dmr_n, sack_n, dmgo_n, ad_oe}, 8'b11111110);
        chk("reset_ad_out", ad_out_n, 16'hFFFF);
        chk("reset_status", {ack, err, busy, rdata}, 19'h0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            xfer(tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, 1'b0, tbl[i].exp_rd, dl);
            if (tbl[i].w) model_write(tbl[i].a, tbl[i].d, tbl[i].b);
        end
        last_rd = 16'hBE34;

        mute = 1'b1;
        xfer(1'b0, 1'b0, 16'o001000, 16'h0000, 1'b1, last_rd, dl);
        chk("timeout_din_cycles", dl, 8);
        mute = 1'b0;

        grant_auto = 1'b0; grant_manual = 1'b0;
        @(posedge clk); #1;
        chk("dmgo_follows_0", dmgo_n, 0);
        grant_manual = 1'b1; #1;
        chk("dmgo_follows_1", dmgo_n, 1);
        we = 1'b0; byt = 1'b0; addr = 16'o001000; req = 1'b1;
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            req = 1'b0;
            if (!dmr_n) cnt++;
            if (dmgo_n !== 1'b1) cnt2++;
        end
        chk("dmr_wait_cycles", cnt, 20);
        other_sync_n = 1'b0; grant_manual = 1'b0;
        @(posedge clk); #1;
        chk("grant_entered", {dmr_n, sack_n}, 2'b10);
        grant_manual = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ad_oe || !sync_n) cnt++;
            if (dmgo_n !== 1'b1) cnt2++;
        end
        chk("addr_held_off", cnt, 0);
        other_sync_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk); #1;
            if (dmgo_n !== 1'b1) cnt2++;
            if (ack) found = 1'b1;
        end
        chk("grant_xfer_ack", {found, err}, 2'b10);
        chk("grant_xfer_rdata", rdata, last_rd);
        chk("dmgo_blocked", cnt2, 0);
        grant_auto = 1'b1;

        mute = 1'b1;
        @(posedge clk); #1;
        we = 1'b1; byt = 1'b0; addr = 16'o000400; wdata = 16'hFFFF; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk); #1;
            if (!dout_n) found = 1'b1;
        end
        chk("reach_wstb", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_bus", {dout_n, sync_n, sack_n, din_n, dmr_n, wtbt_n, ad_oe}, 7'b1111110);
        chk("rst_async_status", {ack, busy, ad_out_n}, {2'b00, 16'hFFFF});
        cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack) cnt++;
        end
        chk("no_ack_in_reset", cnt, 0);
        @(negedge clk); rst = 1'b0; mute = 1'b0;
        last_rd = 16'h0000;
        #1 chk("rdata_after_reset", rdata, 16'h0000);
        xfer(1'b0, 1'b0, 16'o000400, 16'h0000, 1'b0, ref_mem[16'o000400 >> 1], dl);
        last_rd = ref_mem[16'o000400 >> 1];

        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 1023));
            d = 16'($urandom);
            resp_delay = $urandom_range(0, 2);
            e = w ? last_rd : ref_mem[a[9:1]];
            xfer(w, b, a, d, 1'b0, e, dl);
            if (w) model_write(a, d, b);
            else last_rd = e;
        end

        cnt = 0;
        for (int i = 0; i < 512; i++) if (ram[i] !== ref_mem[i]) cnt++;
        chk("ram_image", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
